green_seq: RTL and testbench

//  Fetch/execute sequencer for the green circuit: owns PC, instruction register and the RA/RB registers.

---
 rtl/green_seq_if.sv | 23 ++
 rtl/green_seq.sv | 131 +++++++++++++
 tb/tb_green_seq.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/green_seq_if.sv
// Shared-memory request/acknowledge bus between the green sequencer and its memory.
// The master drives address, read/write requests and store data; the slave returns read data and ack.
interface green_seq_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 8
);
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_wr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  modport master (
    output mem_addr, mem_rd, mem_wr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_addr, mem_rd, mem_wr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/green_seq.sv
// Fetch/execute sequencer for the green circuit: owns PC, IR, RA/RB and MDR.
// It fetches over the req/ack bus, feeds DECOG, and writes DECOG's RA_OUT/RB_OUT back.
module green_seq #(
  parameter int unsigned DW       = 16,
  parameter int unsigned AW       = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic           clk,
  input  logic           rst,
  green_seq_if.master    mem_bus,
  output logic [15:0]    ins,
  output logic [DW-1:0]  RA,
  output logic [DW-1:0]  RB,
  output logic [DW-1:0]  lda,
  output logic [DW-1:0]  ldb,
  output logic [DW-1:0]  inca,
  output logic [DW-1:0]  incb,
  input  logic [DW-1:0]  RA_OUT,
  input  logic [DW-1:0]  RB_OUT,
  input  logic           WE,
  output logic [AW-1:0]  pc,
  output logic           halted
);

  localparam logic [3:0] OP_LOAD = 4'b0000;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [15:0]   ins_q, ins_d;
  logic [DW-1:0] ra_q, ra_d;
  logic [DW-1:0] rb_q, rb_d;
  logic [DW-1:0] mdr_q, mdr_d;
  logic          rd_c, wr_c;
  logic [AW-1:0] addr_c;
  logic          is_load;

  assign is_load = (ins_q[15:12] == OP_LOAD);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= AW'(RESET_PC);
      ins_q   <= 16'h0000;
      ra_q    <= '0;
      rb_q    <= '0;
      mdr_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ins_q   <= ins_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      mdr_q   <= mdr_d;
    end
  end

  // Next-state and bus request decode
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ins_d   = ins_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    mdr_d   = mdr_q;
    rd_c    = 1'b0;
    wr_c    = 1'b0;
    addr_c  = ins_q[AW-1:0];
    case (state_q)
      S_FETCH: begin
        rd_c   = 1'b1;
        addr_c = pc_q;
        if (mem_bus.mem_ack) begin
          ins_d   = 16'(mem_bus.mem_rdata);
          pc_d    = pc_q + AW'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (ins_q[15:12] == OP_HALT)  state_d = S_HALT;
        else if (is_load || WE)       state_d = S_MEM;
        else                          state_d = S_WB;
      end
      S_MEM: begin
        rd_c = is_load;
        wr_c = !is_load;
        if (mem_bus.mem_ack) begin
          if (is_load) mdr_d = mem_bus.mem_rdata;
          state_d = S_WB;
        end
      end
      S_WB: begin
        ra_d    = RA_OUT;
        rb_d    = RB_OUT;
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Requests are gated by rst so an in-flight transaction drops the instant reset rises
  assign mem_bus.mem_rd    = rd_c & ~rst;
  assign mem_bus.mem_wr    = wr_c & ~rst;
  assign mem_bus.mem_addr  = addr_c;
  assign mem_bus.mem_wdata = ins_q[11] ? rb_q : ra_q;

  assign ins    = ins_q;
  assign RA     = ra_q;
  assign RB     = rb_q;
  assign lda    = mdr_q;
  assign ldb    = mdr_q;
  assign inca   = ra_q + DW'(1);
  assign incb   = rb_q + DW'(1);
  assign pc     = pc_q;
  assign halted = (state_q == S_HALT);

endmodule

// File: tb/tb_green_seq.sv
// Bench for green_seq: ISA-level program model with per-instruction latency, a bus memory
// with configurable wait states, and a per-cycle checker for bus and increment invariants.
module tb_green_seq;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  green_seq_if #(.DW(DW), .AW(AW)) bus ();

  logic [15:0]   ins;
  logic [DW-1:0] ra, rb, lda, ldb, inca, incb, ra_out, rb_out;
  logic          we;
  logic [AW-1:0] pc;
  logic          halted;

  green_seq #(.DW(DW), .AW(AW), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .mem_bus(bus),
    .ins(ins), .RA(ra), .RB(rb), .lda(lda), .ldb(ldb), .inca(inca), .incb(incb),
    .RA_OUT(ra_out), .RB_OUT(rb_out), .WE(we), .pc(pc), .halted(halted)
  );

  // DECOG stand-in: selects load/increment candidates or passes registers through
  assign ra_out = (ins[15:12] == 4'h0 && !ins[11]) ? lda :
                  (ins[15:12] == 4'h2 && !ins[11]) ? inca : ra;
  assign rb_out = (ins[15:12] == 4'h0 &&  ins[11]) ? ldb :
                  (ins[15:12] == 4'h2 &&  ins[11]) ? incb : rb;
  assign we     = (ins[15:12] == 4'h1);

  int vec = 0;
  int fails = 0;

  logic [DW-1:0] mem_arr [256];
  int            wait_n = 0;
  int            wcnt = 0;
  logic          spur = 1'b0;
  int            wr_cycles = 0;
  logic [AW-1:0] last_waddr = '0;
  logic [DW-1:0] last_wdata = '0;
  bit            chk_en = 1'b0;
  bit            hold_chk = 1'b0;

  // Memory: acks after wait_n wait cycles; outside a request it only drives the spurious ack
  always @(negedge clk) begin
    if (rst) begin
      bus.mem_ack = 1'b0;
      wcnt = 0;
    end else if (bus.mem_rd || bus.mem_wr) begin
      if (bus.mem_wr) wr_cycles++;
      if (wcnt >= wait_n) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mem_arr[bus.mem_addr];
        wcnt = 0;
      end else begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'hDEAD;
        wcnt++;
      end
    end else begin
      bus.mem_ack   = spur;
      bus.mem_rdata = 16'hDEAD;
      wcnt = 0;
    end
  end

  always @(posedge clk) begin
    if (!rst && bus.mem_ack && bus.mem_wr) begin
      mem_arr[bus.mem_addr] = bus.mem_wdata;
      last_waddr = bus.mem_addr;
      last_wdata = bus.mem_wdata;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle invariants
  always @(negedge clk) begin
    if (!rst && chk_en) begin
      chk("rd_wr_exclusive", 32'(bus.mem_rd & bus.mem_wr), 32'd0);
      chk("inca", 32'(inca), 32'(DW'(ra + DW'(1))));
      chk("incb", 32'(incb), 32'(DW'(rb + DW'(1))));
      chk("lda_eq_ldb", 32'(lda), 32'(ldb));
      if (hold_chk) begin
        chk("halt_no_req", 32'(bus.mem_rd | bus.mem_wr), 32'd0);
        chk("halt_flag", 32'(halted), 32'd1);
      end
    end
  end

  // Architectural model
  logic [DW-1:0] mm [256];
  logic [DW-1:0] m_ra, m_rb;
  logic [AW-1:0] m_pc;
  bit            m_halt;

  task automatic fill(input logic [DW-1:0] v);
    for (int i = 0; i < 256; i++) begin
      mem_arr[i] = v;
      mm[i] = v;
    end
  endtask

  task automatic poke(input int a, input logic [DW-1:0] v);
    mem_arr[a] = v;
    mm[a] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    spur = 1'b0;
    hold_chk = 1'b0;
    m_pc = '0; m_ra = '0; m_rb = '0; m_halt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_ra_rb", {ra, rb}, 32'd0);
    chk("rst_halted_rd", 32'({halted, bus.mem_rd, bus.mem_wr}), 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;
  endtask

  // Run n instructions; instruction spur_idx gets an ack pulse while in DECODE
  task automatic exec(input int n, input int spur_idx);
    for (int k = 0; k < n; k++) begin
      logic [15:0]   iw;
      logic [3:0]    op;
      logic [AW-1:0] ea;
      int            lat;
      bit            memop;
      bit            halt_next;
      iw = 16'(mm[m_pc]);
      op = iw[15:12];
      ea = iw[AW-1:0];
      m_pc = m_pc + AW'(1);
      memop = (op == 4'h0) || (op == 4'h1);
      halt_next = (op == 4'hF);
      case (op)
        4'h0: if (iw[11]) m_rb = mm[ea]; else m_ra = mm[ea];
        4'h1: mm[ea] = iw[11] ? m_rb : m_ra;
        4'h2: if (iw[11]) m_rb = m_rb + DW'(1); else m_ra = m_ra + DW'(1);
        default: ;
      endcase
      lat = halt_next ? 2 + wait_n : 3 + wait_n + (memop ? 1 + wait_n : 0);
      if (k == spur_idx) begin
        repeat (1 + wait_n) @(posedge clk);
        #1 spur = 1'b1;
        @(posedge clk);
        #1 spur = 1'b0;
        repeat (lat - 2 - wait_n) @(posedge clk);
      end else begin
        repeat (lat) @(posedge clk);
      end
      #1;
      if (halt_next) m_halt = 1'b1;
      hold_chk = m_halt;
      chk("model_ra", 32'(ra), 32'(m_ra));
      chk("model_rb", 32'(rb), 32'(m_rb));
      chk("model_pc", 32'(pc), 32'(m_pc));
      chk("model_halted", 32'(halted), 32'(m_halt));
      if (op == 4'h1) chk("model_store", 32'(mem_arr[ea]), 32'(mm[ea]));
    end
  endtask

  initial begin
    rst = 1'b1;

    // Reset aborts a pending fetch
    fill(16'hF000);
    poke(0, 16'h2000);
    wait_n = 2;
    do_reset();
    @(posedge clk);
    #3;
    chk("t1_rd_pending", 32'(bus.mem_rd), 32'd1);
    rst = 1'b1;
    #1;
    chk("t1_rd_drop", 32'(bus.mem_rd), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("t1_refetch", {bus.mem_rd, 7'd0, bus.mem_addr, pc}, {1'b1, 7'd0, 8'h00, 8'h00});
    chk("t1_regs", {ra, rb}, 32'd0);
    exec(1, -1);
    chk("t1_ra", 32'(ra), 32'd1);

    // INC on RA then RB, then HALT holds everything
    fill(16'hF000);
    poke(0, 16'h2000);
    poke(1, 16'h2800);
    wait_n = 0;
    do_reset();
    exec(1, -1);
    chk("t2_ra_cyc3", 32'(ra), 32'd1);
    exec(1, -1);
    chk("t2_rb_cyc6", 32'(rb), 32'd1);
    chk("t2_pc", 32'(pc), 32'd2);
    exec(1, -1);
    chk("t5_halted", 32'(halted), 32'd1);
    repeat (20) @(posedge clk);
    #1;
    chk("t5_hold", {ra, rb}, {16'h0001, 16'h0001});
    chk("t5_pc", 32'(pc), 32'd3);

    // LOAD both registers, INC RB, STORE RB with three wait states
    fill(16'hF000);
    poke(0, 16'h0010);
    poke(1, 16'h0810);
    poke(2, 16'h2800);
    poke(3, 16'h1820);
    poke(16, 16'hBEEF);
    wait_n = 3;
    do_reset();
    exec(2, -1);
    chk("t3_ra", 32'(ra), 32'h0000BEEF);
    chk("t3_rb_ldb", 32'(rb), 32'h0000BEEF);
    exec(1, -1);
    wr_cycles = 0;
    exec(1, -1);
    chk("t3_waddr", 32'(last_waddr), 32'h20);
    chk("t3_wdata", 32'(last_wdata), 32'h0000BEF0);
    chk("t3_wr_held", 32'(wr_cycles), 32'd4);
    exec(1, -1);

    // RA wraps 16'hFFFF -> 0
    fill(16'hF000);
    poke(0, 16'h0010);
    poke(1, 16'h2000);
    poke(16, 16'hFFFF);
    wait_n = 0;
    do_reset();
    exec(1, -1);
    chk("t4_ra_ffff", 32'(ra), 32'h0000FFFF);
    exec(1, -1);
    chk("t4_ra_wrap", 32'(ra), 32'd0);
    exec(1, -1);

    // PC wraps 8'hFF -> 8'h00 through a memory of NOPs
    fill(16'h5000);
    poke(0, 16'h2000);
    wait_n = 0;
    do_reset();
    exec(255, -1);
    chk("t4_pc_ff", 32'(pc), 32'hFF);
    exec(1, -1);
    chk("t4_pc_wrap", {bus.mem_rd, 15'd0, 8'(bus.mem_addr), pc}, {1'b1, 15'd0, 8'h00, 8'h00});
    exec(1, -1);
    chk("t4_ra_after_wrap", 32'(ra), 32'd2);

    // NOP with a spurious ack during DECODE
    fill(16'hF000);
    poke(0, 16'h2000);
    poke(1, 16'h5800);
    wait_n = 0;
    do_reset();
    exec(1, -1);
    exec(1, 0);
    chk("t6_regs", {ra, rb}, {16'h0001, 16'h0000});
    chk("t6_pc", 32'(pc), 32'd2);
    exec(1, -1);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
    $finish;
  end
endmodule
